// File: rtl/mac_seq.sv
// Sequencer that streams signed 8-bit operand pairs into an external MAC and
// captures the final accumulator value as a dot-product result.
module mac_seq #(
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_vld,
    input  logic signed [7:0]  in_a,
    input  logic signed [7:0]  in_b,
    output logic               in_rdy,
    output logic signed [7:0]  mac_a,
    output logic signed [7:0]  mac_b,
    output logic               mac_clr_n,
    input  logic signed [25:0] mac_acc,
    output logic signed [25:0] res,
    output logic               res_vld,
    input  logic               res_rdy,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic signed [25:0]     res_q, res_d;
    logic                   beat;

    assign beat = in_vld && (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Operands reach the MAC only on a real beat; zero operands make the
    // accumulator hold across gaps and in every non-RUN state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        in_rdy    = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        mac_clr_n = 1'b1;
        res_vld   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    state_d = CLR;
                end
            end
            CLR: begin
                mac_clr_n = 1'b0;
                state_d   = (cnt_q != '0) ? RUN : DRAIN;
            end
            RUN: begin
                in_rdy = 1'b1;
                if (beat) begin
                    mac_a = in_a;
                    mac_b = in_b;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last product lands in mac_acc at the end of the beat cycle.
                res_d   = mac_acc;
                state_d = OUT;
            end
            OUT: begin
                res_vld = 1'b1;
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign res  = res_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: an external MAC model plus a plain
// sum-of-products reference, driven with random operands, gaps and stalls.
module tb_mac_seq;
    localparam int LEN_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               in_vld;
    logic signed [7:0]  in_a, in_b;
    logic               in_rdy;
    logic signed [7:0]  mac_a, mac_b;
    logic               mac_clr_n;
    logic signed [25:0] mac_acc = '0;
    logic signed [25:0] res;
    logic               res_vld;
    logic               res_rdy;
    logic               busy;

    int n_chk = 0;
    int n_fail = 0;
    logic signed [7:0] va [256];
    logic signed [7:0] vb [256];

    mac_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_vld(in_vld), .in_a(in_a), .in_b(in_b), .in_rdy(in_rdy),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr_n(mac_clr_n), .mac_acc(mac_acc),
        .res(res), .res_vld(res_vld), .res_rdy(res_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    // External MAC: synchronous active-low clear, otherwise acc += a*b.
    always @(posedge clk) begin
        if (!mac_clr_n) mac_acc <= '0;
        else            mac_acc <= mac_acc + 26'(mac_a) * 26'(mac_b);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full dot product: n pairs from va/vb, random gaps up to max_gap,
    // res_rdy held low for hold cycles in OUT (optionally poking start).
    task automatic do_op(input int n, input int max_gap, input int hold, input bit poke, input string tag);
        int exp_sum;
        logic signed [25:0] exp_res;
        int lat;
        int gap;
        exp_sum = 0;
        for (int i = 0; i < n; i++) exp_sum += int'(va[i]) * int'(vb[i]);
        exp_res = 26'(exp_sum);

        start = 1'b1; len = n[LEN_W-1:0]; in_vld = 1'b0; res_rdy = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0 || in_rdy !== 1'b0) begin n_fail++; $display("FAIL %s idle: busy=%b in_rdy=%b want 0/0", tag, busy, in_rdy); end
        step;
        start = 1'b0; len = LEN_W'($urandom);
        #1;
        n_chk++; if (mac_clr_n !== 1'b0 || in_rdy !== 1'b0 || busy !== 1'b1 || mac_a !== 8'sd0)
            begin n_fail++; $display("FAIL %s clr: clr_n=%b in_rdy=%b busy=%b mac_a=%0d want 0/0/1/0", tag, mac_clr_n, in_rdy, busy, mac_a); end
        step;

        for (int i = 0; i < n; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_vld = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
                #1;
                n_chk++; if (in_rdy !== 1'b1 || mac_a !== 8'sd0 || mac_b !== 8'sd0 || mac_clr_n !== 1'b1)
                    begin n_fail++; $display("FAIL %s gap%0d: in_rdy=%b mac_a=%0d mac_b=%0d clr_n=%b want 1/0/0/1", tag, i, in_rdy, mac_a, mac_b, mac_clr_n); end
                step;
            end
            in_vld = 1'b1; in_a = va[i]; in_b = vb[i];
            #1;
            n_chk++; if (in_rdy !== 1'b1 || mac_a !== va[i] || mac_b !== vb[i])
                begin n_fail++; $display("FAIL %s beat%0d: in_rdy=%b mac_a=%0d mac_b=%0d want 1/%0d/%0d", tag, i, in_rdy, mac_a, mac_b, va[i], vb[i]); end
            step;
        end

        in_vld = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
        lat = (n == 0) ? 2 : 1;
        while (res_vld !== 1'b1 && lat < 12) begin
            #1;
            n_chk++; if (in_rdy !== 1'b0 || mac_a !== 8'sd0 || mac_b !== 8'sd0)
                begin n_fail++; $display("FAIL %s drain: in_rdy=%b mac_a=%0d mac_b=%0d want 0/0/0", tag, in_rdy, mac_a, mac_b); end
            step;
            lat++;
        end
        n_chk++; if (lat !== ((n == 0) ? 3 : 2)) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, (n == 0) ? 3 : 2); end
        n_chk++; if (res !== exp_res) begin n_fail++; $display("FAIL %s res: got %0d want %0d", tag, res, exp_res); end
        in_vld = 1'b0;

        for (int h = 0; h < hold; h++) begin
            res_rdy = 1'b0; start = poke; len = LEN_W'($urandom);
            #1;
            n_chk++; if (res_vld !== 1'b1 || res !== exp_res || in_rdy !== 1'b0 || busy !== 1'b1)
                begin n_fail++; $display("FAIL %s hold%0d: res_vld=%b res=%0d in_rdy=%b busy=%b want 1/%0d/0/1", tag, h, res_vld, res, in_rdy, busy, exp_res); end
            step;
        end
        start = 1'b0; res_rdy = 1'b1;
        step;
        res_rdy = 1'b0;
        #1;
        n_chk++; if (res_vld !== 1'b0 || busy !== 1'b0 || res !== exp_res)
            begin n_fail++; $display("FAIL %s release: res_vld=%b busy=%b res=%0d want 0/0/%0d", tag, res_vld, busy, res, exp_res); end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; len = '0; in_vld = 1'b1; in_a = 8'sd5; in_b = 8'sd7; res_rdy = 1'b0;
        #3;
        n_chk++; if (res !== 26'sd0 || res_vld !== 1'b0 || in_rdy !== 1'b0 || busy !== 1'b0 || mac_a !== 8'sd0 || mac_b !== 8'sd0 || mac_clr_n !== 1'b1)
            begin n_fail++; $display("FAIL reset: res=%0d vld=%b rdy=%b busy=%b a=%0d b=%0d clr_n=%b want 0/0/0/0/0/0/1", res, res_vld, in_rdy, busy, mac_a, mac_b, mac_clr_n); end
        step; step;
        rst = 1'b0; in_vld = 1'b0;
    endtask

    task automatic test_directed;
        va[0] = 8'sd1;  vb[0] = 8'sd2;
        va[1] = 8'sd3;  vb[1] = 8'sd4;
        va[2] = -8'sd5; vb[2] = 8'sd6;
        va[3] = 8'sd7;  vb[3] = -8'sd8;
        do_op(4, 0, 0, 1'b0, "b2b4");
        n_chk++; if (res !== 26'h3FFFFB8) begin n_fail++; $display("FAIL b2b4_const: got %h want 3ffffb8", res); end
        va[0] = 8'sd10; vb[0] = 8'sd10;
        va[1] = -8'sd1; vb[1] = 8'sd1;
        va[2] = 8'sd2;  vb[2] = 8'sd3;
        do_op(3, 4, 0, 1'b0, "gaps3");
        n_chk++; if (res !== 26'sd105) begin n_fail++; $display("FAIL gaps3_const: got %0d want 105", res); end
    endtask

    task automatic test_max_len;
        for (int i = 0; i < 255; i++) begin va[i] = -8'sd128; vb[i] = -8'sd128; end
        do_op(255, 0, 0, 1'b0, "max255");
        n_chk++; if (res !== 26'h03FC000) begin n_fail++; $display("FAIL max255_const: got %h want 03fc000", res); end
    endtask

    task automatic test_len_zero;
        do_op(0, 0, 0, 1'b0, "len0");
    endtask

    task automatic test_stall_out;
        va[0] = 8'sd9; vb[0] = -8'sd11;
        va[1] = 8'sd4; vb[1] = 8'sd25;
        do_op(2, 1, 5, 1'b1, "stall");
    endtask

    task automatic test_mid_reset;
        start = 1'b1; len = 8'd5;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 2; i++) begin
            in_vld = 1'b1; in_a = 8'sd50; in_b = 8'sd60;
            step;
        end
        in_vld = 1'b1; in_a = 8'sd17; in_b = 8'sd19;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (res !== 26'sd0 || res_vld !== 1'b0 || in_rdy !== 1'b0 || busy !== 1'b0 || mac_a !== 8'sd0 || mac_b !== 8'sd0 || mac_clr_n !== 1'b1)
            begin n_fail++; $display("FAIL midreset: res=%0d vld=%b rdy=%b busy=%b a=%0d b=%0d clr_n=%b want 0/0/0/0/0/0/1", res, res_vld, in_rdy, busy, mac_a, mac_b, mac_clr_n); end
        step;
        rst = 1'b0; in_vld = 1'b0;
        va[0] = 8'sd3; vb[0] = 8'sd3;
        do_op(1, 0, 0, 1'b0, "after_rst");
        n_chk++; if (res !== 26'sd9) begin n_fail++; $display("FAIL after_rst_const: got %0d want 9", res); end
    endtask

    task automatic test_random;
        int n;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
            do_op(n, 2, int'($urandom_range(0, 3)), 1'($urandom), "rand");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_max_len;
        test_len_zero;
        test_stall_out;
        test_mid_reset;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter: LEN_W, default 8, width of term-count input len.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a dot product; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of operand pairs (0..2^LEN_W-1), sampled with start.
REQ-006 in_vld  input  1  operand pair valid.
REQ-007 in_a  input  8  signed operand A.
REQ-008 in_b  input  8  signed operand B.
REQ-009 in_rdy  output  1  block accepts operand pair this cycle.
REQ-010 mac_a  output  8  operand A to MAC.
REQ-011 mac_b  output  8  operand B to MAC.
REQ-012 mac_clr_n  output  1  MAC synchronous clear, active-low.
REQ-013 mac_acc  input  26  MAC accumulator, two's complement; updates as acc += mac_a*mac_b every clock unless cleared.
REQ-014 res  output  26  captured dot-product result, two's complement.
REQ-015 res_vld  output  1  res valid.
REQ-016 res_rdy  input  1  downstream accepts res.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, CLR, RUN, DRAIN, OUT.
REQ-019 IDLE: in_rdy=0, mac_clr_n=1, mac_a=mac_b=0; start=1 -> latch len into term counter, go CLR.
REQ-020 CLR: exactly one cycle, mac_clr_n=0, mac_a=mac_b=0, in_rdy=0; next RUN if counter!=0, else DRAIN.
REQ-021 RUN: in_rdy=1; beat = in_vld&in_rdy; on beat, mac_a=in_a and mac_b=in_b combinationally in the same cycle, counter decrements.
REQ-022 RUN without beat: mac_a=mac_b=0 so the MAC accumulator holds (gaps in in_vld are legal, unbounded).
REQ-023 RUN: beat with counter==1 -> DRAIN; in_rdy SHALL be 0 from the following cycle.
REQ-024 DRAIN: one cycle, in_rdy=0, mac_a=mac_b=0, mac_clr_n=1; res <= mac_acc at its end; go OUT.
REQ-025 OUT: res_vld=1, res stable; res_vld&res_rdy -> IDLE with res_vld=0 next cycle; res holds its value in IDLE.
REQ-026 Latency: res_vld SHALL rise exactly 2 cycles after the cycle of the last beat (len>=1); 3 cycles after start for len=0.
REQ-027 start outside IDLE SHALL be ignored; len changes outside IDLE SHALL have no effect.
REQ-028 Result SHALL equal the exact signed sum of len products; no saturation needed (max |sum| 255*16384 < 2^25).
REQ-029 res SHALL be passed bit-exact from mac_acc, no rounding or truncation.

Reset
REQ-030 rst=1 SHALL force IDLE immediately: res=0, res_vld=0, in_rdy=0, busy=0, mac_a=mac_b=0, mac_clr_n=1, counter=0.
REQ-031 Reset mid-operation SHALL abandon the operation; the next operation SHALL be unaffected because CLR clears the MAC.

Verification
REQ-032 len=4, pairs (1,2),(3,4),(-5,6),(7,-8) back-to-back -> res=-72 (26'h3FFFFB8), res_vld 2 cycles after 4th beat.
REQ-033 len=255, all pairs (-128,-128) -> res=4177920 (26'h03FC000).
REQ-034 len=3, pairs (10,10),(-1,1),(2,3) with 0-4 idle cycles between beats -> res=105; mac_a=mac_b=0 on every gap cycle.
REQ-035 len=0 -> no in_rdy ever; res=0, res_vld 3 cycles after start.
REQ-036 res_rdy low 5 cycles in OUT, start pulsed meanwhile -> res_vld and res stable, start ignored, in_rdy=0; res_rdy=1 -> IDLE.
REQ-037 rst pulsed in RUN after 2 beats -> all outputs at reset values; then len=1, pair (3,3) -> res=9.
